// File: rtl/wb_pwm_multi.sv
// Multi-channel Wishbone PWM slave: one shared prescaled period counter (edge or center
// aligned), shadowed period/duty registers, period-end IRQ and a duty-refresh watchdog.
module wb_pwm_multi #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PRE_W = 8,
  parameter int unsigned WDT_W = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     wb_adr_i,
  input  logic [31:0]     wb_dat_i,
  output logic [31:0]     wb_dat_o,
  input  logic [3:0]      wb_sel_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  input  logic            wb_we_i,
  output logic            wb_ack_o,
  output logic [N_CH-1:0] pwm_o,
  output logic            intr,
  output logic            failsafe_o
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PRE_W-1:0] PreOne = {{(PRE_W-1){1'b0}}, 1'b1};
  localparam logic [WDT_W-1:0] WdtOne = {{(WDT_W-1){1'b0}}, 1'b1};

  logic                ack_q;
  logic [31:0]         dat_q, dat_d, rdata, be_mask;
  logic [3:0]          ctrl_q, ctrl_d;
  logic [PRE_W-1:0]    prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]    period_sh_q, period_sh_d, period_act_q, period_act_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    duty_sh_q [N_CH];
  logic [CNT_W-1:0]    duty_sh_d [N_CH];
  logic [CNT_W-1:0]    duty_act_q [N_CH];
  logic [CNT_W-1:0]    duty_act_d [N_CH];
  logic                irq_pend_q, irq_pend_d, failsafe_q, failsafe_d, dir_q, dir_d;
  logic [WDT_W-1:0]    wdt_reload_q, wdt_reload_d, wdt_cnt_q, wdt_cnt_d;
  logic [N_CH-1:0]     pwm_q, pwm_d;

  logic       acc, wr, is_duty, wr_duty, irq_clr, fs_clr, wdt_load, trip, tick, boundary;
  logic       en, center, irq_en, inv;
  logic [5:0] widx;
  logic [3:0] dch;
  logic       unused_bits;

  assign en     = ctrl_q[0];
  assign center = ctrl_q[1];
  assign irq_en = ctrl_q[2];
  assign inv    = ctrl_q[3];

  // Data is captured on the same edge that raises ack, so only the first strobe cycle counts.
  assign acc     = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr      = acc & wb_we_i;
  assign widx    = wb_adr_i[7:2];
  assign dch     = widx[3:0];
  assign is_duty = (widx[5:4] == 2'b01) && (32'(dch) < N_CH);
  assign wr_duty = wr & is_duty;
  assign irq_clr = wr && (widx == 6'd3) && wb_sel_i[0] && wb_dat_i[0];
  assign fs_clr  = wr && (widx == 6'd3) && wb_sel_i[0] && wb_dat_i[1];
  assign be_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign unused_bits = ^{wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i, be_mask};

  always_comb begin
    ctrl_d       = ctrl_q;
    prescale_d   = prescale_q;
    period_sh_d  = period_sh_q;
    wdt_reload_d = wdt_reload_q;
    if (wr && widx == 6'd0) begin
      ctrl_d = (ctrl_q & ~be_mask[3:0]) | (wb_dat_i[3:0] & be_mask[3:0]);
    end
    if (wr && widx == 6'd1) begin
      prescale_d = (prescale_q & ~be_mask[PRE_W-1:0]) | (wb_dat_i[PRE_W-1:0] & be_mask[PRE_W-1:0]);
    end
    if (wr && widx == 6'd2) begin
      period_sh_d = (period_sh_q & ~be_mask[CNT_W-1:0]) |
                    (wb_dat_i[CNT_W-1:0] & be_mask[CNT_W-1:0]);
    end
    if (wr && widx == 6'd4) begin
      wdt_reload_d = (wdt_reload_q & ~be_mask[WDT_W-1:0]) |
                     (wb_dat_i[WDT_W-1:0] & be_mask[WDT_W-1:0]);
    end
    for (int i = 0; i < N_CH; i++) begin
      duty_sh_d[i] = duty_sh_q[i];
      if (wr_duty && dch == i[3:0]) begin
        duty_sh_d[i] = (duty_sh_q[i] & ~be_mask[CNT_W-1:0]) |
                       (wb_dat_i[CNT_W-1:0] & be_mask[CNT_W-1:0]);
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (widx)
      6'd0:    rdata = 32'(ctrl_q);
      6'd1:    rdata = 32'(prescale_q);
      6'd2:    rdata = 32'(period_sh_q);
      6'd3:    rdata = {30'b0, failsafe_q, irq_pend_q};
      6'd4:    rdata = 32'(wdt_reload_q);
      6'd5:    rdata = 32'(count_q);
      default: rdata = '0;
    endcase
    for (int i = 0; i < N_CH; i++) begin
      if (is_duty && dch == i[3:0]) rdata = 32'(duty_sh_q[i]);
    end
    dat_d = acc ? rdata : dat_q;
  end

  // Shared counter: edge mode wraps after PERIOD, center mode bounces between PERIOD and 0.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    count_d   = count_q;
    dir_d     = dir_q;
    tick      = en && (pre_cnt_q == prescale_q);
    boundary  = 1'b0;
    if (!en) begin
      pre_cnt_d = '0;
      count_d   = '0;
      dir_d     = 1'b0;
    end else begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PreOne;
      if (tick) begin
        if (!center) begin
          dir_d = 1'b0;
          if (count_q >= period_act_q) begin
            count_d  = '0;
            boundary = 1'b1;
          end else begin
            count_d = count_q + CntOne;
          end
        end else if (!dir_q) begin
          if (count_q < period_act_q) begin
            count_d = count_q + CntOne;
          end else if (period_act_q <= CntOne) begin
            count_d  = '0;
            boundary = 1'b1;
          end else begin
            count_d = count_q - CntOne;
            dir_d   = 1'b1;
          end
        end else if (count_q <= CntOne) begin
          count_d  = '0;
          dir_d    = 1'b0;
          boundary = 1'b1;
        end else begin
          count_d = count_q - CntOne;
        end
      end
    end
    period_act_d = (!en || boundary) ? period_sh_q : period_act_q;
    for (int i = 0; i < N_CH; i++) begin
      duty_act_d[i] = (!en || boundary) ? duty_sh_q[i] : duty_act_q[i];
    end
  end

  // A reload on the expiry edge wins, so a timely duty refresh never trips the failsafe.
  always_comb begin
    wdt_load   = wr_duty || (wr && widx == 6'd4) || fs_clr;
    trip       = !wdt_load && (wdt_reload_q != '0) && (wdt_cnt_q == WdtOne);
    wdt_cnt_d  = wdt_cnt_q;
    if (wdt_load) begin
      wdt_cnt_d = wdt_reload_d;
    end else if (wdt_cnt_q != '0 && wdt_reload_q != '0) begin
      wdt_cnt_d = wdt_cnt_q - WdtOne;
    end
    failsafe_d = trip || (failsafe_q && !fs_clr);
    irq_pend_d = boundary || (irq_pend_q && !irq_clr);
    for (int i = 0; i < N_CH; i++) begin
      pwm_d[i] = (en && !failsafe_q) ? ((count_q < duty_act_q[i]) ^ inv) : inv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q        <= 1'b0;
      dat_q        <= '0;
      ctrl_q       <= '0;
      prescale_q   <= '0;
      pre_cnt_q    <= '0;
      period_sh_q  <= '0;
      period_act_q <= '0;
      count_q      <= '0;
      dir_q        <= 1'b0;
      irq_pend_q   <= 1'b0;
      failsafe_q   <= 1'b0;
      wdt_reload_q <= '0;
      wdt_cnt_q    <= '0;
      pwm_q        <= '0;
      for (int i = 0; i < N_CH; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
    end else begin
      ack_q        <= acc;
      dat_q        <= dat_d;
      ctrl_q       <= ctrl_d;
      prescale_q   <= prescale_d;
      pre_cnt_q    <= pre_cnt_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      count_q      <= count_d;
      dir_q        <= dir_d;
      irq_pend_q   <= irq_pend_d;
      failsafe_q   <= failsafe_d;
      wdt_reload_q <= wdt_reload_d;
      wdt_cnt_q    <= wdt_cnt_d;
      pwm_q        <= pwm_d;
      for (int i = 0; i < N_CH; i++) begin
        duty_sh_q[i]  <= duty_sh_d[i];
        duty_act_q[i] <= duty_act_d[i];
      end
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign pwm_o      = pwm_q;
  assign intr       = irq_pend_q & irq_en;
  assign failsafe_o = failsafe_q;

endmodule

// File: doc/wb_pwm_multi.md
# wb_pwm_multi

Parametrised multi-channel Wishbone PWM slave for the LM32 SoC, the next generation of the fixed 4-motor PWM peripheral. Drives N_CH outputs from one shared prescaled period counter with edge- or center-aligned mode, shadowed period and duty registers, and a period-end interrupt. A write watchdog forces every output to its idle level if firmware stops refreshing duties, which is the failsafe the quadcopter motors require. Sits on a conbus slave port with one line on intr_n.

## Interface
- N_CH, 4: channel count, 1..16
- CNT_W, 16: width of the period counter, PERIOD and DUTY registers
- PRE_W, 8: prescaler width
- WDT_W, 24: watchdog width, in clk cycles
- clk  in  1  system clock; the block's only clock
- rst  in  1  reset, asynchronous, active-low
- wb_adr_i  in  32  Wishbone address; bits [7:2] decoded
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, registered
- wb_sel_i  in  4  byte enables; honoured on writes
- wb_stb_i, wb_cyc_i, wb_we_i  in  1  Wishbone strobe, cycle, write enable
- wb_ack_o  out  1  single-cycle acknowledge
- pwm_o  out  N_CH  PWM outputs, registered
- intr  out  1  period-end interrupt, active-high
- failsafe_o  out  1  watchdog tripped

## Operation
- Register map, byte offsets:
  - 0x00 CTRL: bit0 EN, bit1 CENTER, bit2 IRQ_EN, bit3 INV (idle/active polarity)
  - 0x04 PRESCALE: tick every PRESCALE+1 clks
  - 0x08 PERIOD (shadow)
  - 0x0C STATUS: bit0 IRQ_PEND, bit1 FAILSAFE. Both write-1-to-clear.
  - 0x10 WDT reload; 0 disables the watchdog
  - 0x14 COUNT: read-only counter value
  - 0x40+4*i DUTY[i] (shadow), i < N_CH
- Unmapped addresses read 0. Writes to unmapped addresses are ignored.
- Prescaler counts 0..PRESCALE. A tick fires when it equals PRESCALE, then it returns to 0.
- Edge mode: COUNT runs 0..PERIOD on ticks, then wraps to 0. Period is PERIOD+1 ticks.
- Center mode: COUNT runs 0,1..PERIOD,PERIOD-1..1, then repeats. Period is 2*PERIOD ticks.
- Channel active level: active when COUNT < active_duty[i].
  - Edge mode: duty 0 is always idle; duty > PERIOD is always active.
  - Center mode: active for 2*duty-1 ticks when 1 ≤ duty ≤ PERIOD.
- pwm_o[i] = active XOR INV. Idle level = INV.
- Boundary event: the tick on which COUNT returns to 0.
  - Shadow PERIOD and DUTY are copied to the active registers.
  - IRQ_PEND is set.
- intr = IRQ_PEND & IRQ_EN.
- EN=0:
  - Prescaler and COUNT are held at 0.
  - Active registers follow the shadows every cycle.
  - pwm_o is at the idle level.
  - No boundary events occur.
- Watchdog:
  - WDT counter loads WDT on every DUTY write, WDT write, or FAILSAFE clear.
  - Decrements each clk while nonzero and WDT≠0.
  - On the 1→0 transition it sets FAILSAFE.
- While FAILSAFE=1:
  - pwm_o is forced to the idle level.
  - Counting continues.
  - failsafe_o = FAILSAFE.

## Timing
- Reset values:
  - All registers are 0.
  - pwm_o = 0, intr = 0, failsafe_o = 0, wb_ack_o = 0, wb_dat_o = 0.
- Wishbone acknowledge:
  - wb_ack_o <= stb & cyc & ~wb_ack_o, so ack rises one clk after the strobe and is high for one clk.
  - A held strobe gets an ack every other cycle.
- Write data is stored on the edge that raises ack. Read data is valid while ack is high.
- pwm_o is registered and lags COUNT by 1 clk.
- Simultaneous events:
  - Boundary load and a DUTY/PERIOD write in the same cycle: the load takes the old shadow; the new value applies at the next boundary.
  - IRQ_PEND set and W1C clear in the same cycle: set wins.
  - Watchdog expiry and a DUTY write in the same cycle: the write wins, no trip.
  - FAILSAFE set and W1C clear in the same cycle: set wins.
- Writing PERIOD below the current COUNT has no effect until the next boundary. Active PERIOD changes only at boundaries.
- Clearing EN mid-period:
  - COUNT goes to 0 on the next clk.
  - No IRQ is raised.
  - Outputs go idle the following clk.
- Reset asserted mid-operation clears everything immediately (asynchronous). Outputs return to reset values without waiting for clk.

## Test plan
- Edge duty: PRESCALE=0, PERIOD=9, DUTY0=3, EN=1 -> pwm_o[0] high 3 clks then low 7 clks, repeating every 10 clks. IRQ_PEND sets every 10 clks.
- Center mode: PERIOD=4, DUTY1=2, CENTER=1 -> COUNT sequence 0,1,2,3,4,3,2,1. pwm_o[1] high for 3 contiguous clks per 8-clk period.
- Shadow update: change DUTY0 from 3 to 7 mid-period -> the current period keeps 3, the next period shows 7. Duty 0 gives constant low; duty 10 gives constant high.
- Prescaler plus IRQ: PRESCALE=4, PERIOD=1, IRQ_EN=1 -> boundary every 10 clks and intr asserts. W1C on STATUS bit0 drops intr. A clear coinciding with a boundary leaves intr set.
- Watchdog: WDT=100, write DUTY0 -> failsafe_o rises exactly 100 clks after the write's ack and pwm_o goes idle. A DUTY write at clk 99 prevents the trip. W1C on bit1 restores outputs.
- Register map and reset: INV=1 -> idle outputs high. Unmapped read returns 0. Asynchronous reset mid-period drives all outputs to 0 with no clk edge.
